// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with REQ/HOLD handshake, BHT/BTB prediction and IF/ID register
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 16
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        bp_upd_en,
  input  logic [31:0] bp_upd_pc,
  input  logic        bp_upd_taken,
  input  logic [31:0] bp_upd_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] oIR,
  output logic [31:0] oPC,
  output logic        oValid,
  output logic [2:0]  oPPCCB,
  output logic [31:0] oIC
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic {S_REQ, S_HOLD} state_t;

  state_t            state;
  logic [31:0]       pc_q;
  logic [31:0]       ic_q;
  logic [31:0]       hold_ir;
  logic [2:0]        hold_ppccb;
  logic [31:0]       hold_npc;

  logic [1:0]        bht_cnt [BHT_ENTRIES];
  logic [31:0]       btb_tgt [BHT_ENTRIES];
  logic [BHT_ENTRIES-1:0] btb_vld;

  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic [1:0]        pred_cnt;
  logic              pred_taken;
  logic [31:0]       pred_npc;

  // Prediction is read combinationally from registered tables, so a same-cycle
  // update is only visible to the next fetch (read before write).
  always_comb begin
    fetch_idx  = pc_q[IDX_W+1:2];
    upd_idx    = bp_upd_pc[IDX_W+1:2];
    pred_cnt   = bht_cnt[fetch_idx];
    pred_taken = btb_vld[fetch_idx] & pred_cnt[1];
    pred_npc   = pred_taken ? btb_tgt[fetch_idx] : pc_q + 32'd4;
  end

  assign imem_addr = pc_q;
  assign oIC       = ic_q;

  always_ff @(posedge Clk) begin
    if (reset) begin
      state      <= S_REQ;
      imem_req   <= 1'b1;
      pc_q       <= RESET_PC;
      ic_q       <= 32'd0;
      hold_ir    <= 32'd0;
      hold_ppccb <= 3'b001;
      hold_npc   <= RESET_PC;
      oIR        <= 32'd0;
      oPC        <= 32'd0;
      oValid     <= 1'b0;
      oPPCCB     <= 3'b001;
      btb_vld    <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_cnt[i] <= 2'b01;
      end
    end else begin
      if (bp_upd_en) begin
        if (bp_upd_taken) begin
          if (bht_cnt[upd_idx] != 2'b11) bht_cnt[upd_idx] <= bht_cnt[upd_idx] + 2'd1;
          btb_tgt[upd_idx] <= bp_upd_target;
          btb_vld[upd_idx] <= 1'b1;
        end else if (bht_cnt[upd_idx] != 2'b00) begin
          bht_cnt[upd_idx] <= bht_cnt[upd_idx] - 2'd1;
        end
      end

      if (redirect) begin
        pc_q     <= redirect_pc;
        state    <= S_REQ;
        imem_req <= 1'b1;
        oValid   <= 1'b0;
      end else begin
        case (state)
          S_REQ: begin
            if (imem_ready && !stall) begin
              pc_q <= pred_npc;
              // A flushed response still advances PC but never reaches ID.
              if (!flush) begin
                oIR    <= imem_rdata;
                oPC    <= pc_q;
                oValid <= 1'b1;
                oPPCCB <= {pred_taken, pred_cnt};
                ic_q   <= ic_q + 32'd1;
              end
            end else if (imem_ready) begin
              hold_ir    <= imem_rdata;
              hold_ppccb <= {pred_taken, pred_cnt};
              hold_npc   <= pred_npc;
              state      <= S_HOLD;
              imem_req   <= 1'b0;
            end else if (!stall) begin
              oValid <= 1'b0;
            end
          end
          S_HOLD: begin
            if (!stall) begin
              pc_q     <= hold_npc;
              state    <= S_REQ;
              imem_req <= 1'b1;
              if (!flush) begin
                oIR    <= hold_ir;
                oPC    <= pc_q;
                oValid <= 1'b1;
                oPPCCB <= hold_ppccb;
                ic_q   <= ic_q + 32'd1;
              end
            end
          end
          default: begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        endcase
        if (flush) oValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        Clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        bp_upd_en;
  logic [31:0] bp_upd_pc;
  logic        bp_upd_taken;
  logic [31:0] bp_upd_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] oIR;
  logic [31:0] oPC;
  logic        oValid;
  logic [2:0]  oPPCCB;
  logic [31:0] oIC;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .BHT_ENTRIES(16)) dut (
    .Clk(Clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .bp_upd_en(bp_upd_en), .bp_upd_pc(bp_upd_pc),
    .bp_upd_taken(bp_upd_taken), .bp_upd_target(bp_upd_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .oIR(oIR), .oPC(oPC), .oValid(oValid), .oPPCCB(oPPCCB), .oIC(oIC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
    bp_upd_en = 0; bp_upd_pc = 0; bp_upd_taken = 0; bp_upd_target = 0;
    imem_ready = 0; imem_rdata = 0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] data);
    idle();
    imem_ready = 1; imem_rdata = data;
    step();
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    check("rst_oIR", oIR, 32'h0);
    check("rst_oPC", oPC, 32'h0);
    check("rst_oValid", {31'b0, oValid}, 32'd0);
    check("rst_oPPCCB", {29'b0, oPPCCB}, 32'd1);
    check("rst_oIC", oIC, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, 32'h0);

    // Three back-to-back fetches A, B, C
    fetch(32'hAAAA_0001);
    check("a_oIR", oIR, 32'hAAAA_0001);
    check("a_oPC", oPC, 32'h0);
    fetch(32'hBBBB_0002);
    check("b_oPC", oPC, 32'h4);
    fetch(32'hCCCC_0003);
    check("c_oIR", oIR, 32'hCCCC_0003);
    check("c_oPC", oPC, 32'h8);
    check("c_oValid", {31'b0, oValid}, 32'd1);
    check("c_oIC", oIC, 32'd3);
    check("c_oPPCCB", {29'b0, oPPCCB}, 32'd1);
    check("c_addr", imem_addr, 32'hC);

    // Stall coincident with response D -> HOLD
    idle(); imem_ready = 1; imem_rdata = 32'hDDDD_0004; stall = 1;
    step();
    check("hold_req", {31'b0, imem_req}, 32'd0);
    check("hold_oIR", oIR, 32'hCCCC_0003);
    check("hold_oIC", oIC, 32'd3);
    check("hold_addr", imem_addr, 32'hC);
    idle(); stall = 1;
    step();
    check("hold2_oIR", oIR, 32'hCCCC_0003);
    check("hold2_oValid", {31'b0, oValid}, 32'd1);
    idle();
    step();
    check("rel_oIR", oIR, 32'hDDDD_0004);
    check("rel_oPC", oPC, 32'hC);
    check("rel_oIC", oIC, 32'd4);
    check("rel_req", {31'b0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'h10);

    // No response -> bubble, PC held
    idle();
    step();
    check("bub_oValid", {31'b0, oValid}, 32'd0);
    check("bub_addr", imem_addr, 32'h10);

    // Train PC 0x10 taken to 0x80 three times
    for (int i = 0; i < 3; i++) begin
      idle(); bp_upd_en = 1; bp_upd_pc = 32'h10; bp_upd_taken = 1; bp_upd_target = 32'h80;
      step();
    end
    // Fetch 0x10 while a not-taken update hits the same index: pre-update counter seen
    idle(); imem_ready = 1; imem_rdata = 32'hEEEE_0005;
    bp_upd_en = 1; bp_upd_pc = 32'h10; bp_upd_taken = 0;
    step();
    check("bp_oPPCCB", {29'b0, oPPCCB}, 32'd7);
    check("bp_oPC", oPC, 32'h10);
    check("bp_oIC", oIC, 32'd5);
    check("bp_addr", imem_addr, 32'h80);

    // Redirect drops the concurrent response
    idle(); redirect = 1; redirect_pc = 32'h200; imem_ready = 1; imem_rdata = 32'hFFFF_0006;
    step();
    check("rd_oValid", {31'b0, oValid}, 32'd0);
    check("rd_oIR", oIR, 32'hEEEE_0005);
    check("rd_oIC", oIC, 32'd5);
    check("rd_addr", imem_addr, 32'h200);
    fetch(32'h1234_0007);
    check("rd2_oPC", oPC, 32'h200);
    check("rd2_oIC", oIC, 32'd6);
    check("rd2_addr", imem_addr, 32'h204);

    // Flush and stall together with a response H
    idle(); flush = 1; stall = 1; imem_ready = 1; imem_rdata = 32'h5678_0008;
    step();
    check("fs_oValid", {31'b0, oValid}, 32'd0);
    check("fs_oIC", oIC, 32'd6);
    check("fs_req", {31'b0, imem_req}, 32'd0);
    idle();
    step();
    check("fs2_oIR", oIR, 32'h5678_0008);
    check("fs2_oPC", oPC, 32'h204);
    check("fs2_oIC", oIC, 32'd7);
    check("fs2_addr", imem_addr, 32'h208);

    // Refetch 0x10: counter dropped to 2'b10 by the earlier not-taken update
    idle(); redirect = 1; redirect_pc = 32'h10;
    step();
    fetch(32'h9999_0009);
    check("re_oPPCCB", {29'b0, oPPCCB}, 32'd6);
    check("re_addr", imem_addr, 32'h80);

    // Reset while in HOLD
    idle(); stall = 1; imem_ready = 1; imem_rdata = 32'h7777_000A;
    step();
    check("mh_req", {31'b0, imem_req}, 32'd0);
    idle(); reset = 1;
    step();
    check("mr_req", {31'b0, imem_req}, 32'd1);
    check("mr_addr", imem_addr, 32'h0);
    check("mr_oIC", oIC, 32'd0);
    check("mr_oValid", {31'b0, oValid}, 32'd0);
    idle();
    step();
    check("mr2_oValid", {31'b0, oValid}, 32'd0);
    check("mr2_addr", imem_addr, 32'h0);
    idle(); redirect = 1; redirect_pc = 32'h10;
    step();
    fetch(32'h3333_000B);
    check("mr_bht_oPPCCB", {29'b0, oPPCCB}, 32'd1);
    check("mr_bht_addr", imem_addr, 32'h14);
    check("mr_bht_oIC", oIC, 32'd1);

    // Counter wrap
    dut.ic_q = 32'hFFFF_FFFF;
    fetch(32'h4444_000C);
    check("wrap_oIC", oIC, 32'd0);
    check("wrap_oPC", oPC, 32'h14);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter BHT_ENTRIES, default 16 (power of 2), entries in the branch history table (BHT) and target buffer; index = PC[log2(BHT_ENTRIES)+1:2].
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  hold the IF/ID register and PC.
REQ-006 flush  in  1  insert a bubble into the IF/ID register.
REQ-007 redirect  in  1  mispredict or jump correction from EX.
REQ-008 redirect_pc  in  32  corrected fetch address.
REQ-009 bp_upd_en  in  1  resolved branch update strobe.
REQ-010 bp_upd_pc  in  32  PC of the resolved branch.
REQ-011 bp_upd_taken  in  1  resolved branch direction.
REQ-012 bp_upd_target  in  32  resolved branch target.
REQ-013 imem_req  out  1  fetch request.
REQ-014 imem_addr  out  32  fetch address; equals PC.
REQ-015 imem_ready  in  1  imem_rdata valid this cycle.
REQ-016 imem_rdata  in  32  instruction word.
REQ-017 oIR  out  32  IF/ID instruction.
REQ-018 oPC  out  32  IF/ID instruction PC.
REQ-019 oValid  out  1  IF/ID valid.
REQ-020 oPPCCB  out  3  bit [2] is the predicted-taken flag; bits [1:0] are the BHT counter value read at fetch.
REQ-021 oIC  out  32  count of valid instructions delivered to ID.

Function
REQ-022 State machine REQ/HOLD: REQ drives imem_req=1; HOLD drives imem_req=0.
REQ-023 REQ, imem_ready=1, stall=0: the IF/ID register loads {imem_rdata, PC, valid=1, prediction}, oIC increments, and PC takes the next PC in the same edge; the unit stays in REQ.
REQ-024 REQ, imem_ready=1, stall=1: imem_rdata and the prediction are captured in a one-entry hold buffer, PC is unchanged, and the unit moves to HOLD.
REQ-025 HOLD, stall=0: the hold buffer loads into the IF/ID register, PC takes the next PC, oIC increments, and the unit moves to REQ; while stall=1 the unit stays in HOLD.
REQ-026 REQ, imem_ready=0: PC and imem_addr are held, and the IF/ID register loads a bubble (valid=0) unless stall=1.
REQ-027 Next PC = BTB target when the entry is valid and counter[1]=1, otherwise PC+4 (mod 2^32).
REQ-028 stall=1 and no flush: all IF/ID outputs and oIC hold.
REQ-029 flush=1: oValid<=0 on that edge, overriding stall; the other IF/ID fields hold; the PC path is unaffected unless redirect=1.
REQ-030 redirect=1: PC<=redirect_pc, state<=REQ, the hold buffer is discarded, oValid<=0, and any imem_ready response in that cycle is dropped; redirect takes priority over stall.
REQ-031 bp_upd_en=1: the counter at the update index saturates up (taken, max 2'b11) or down (not taken, min 2'b00); when taken, the target is written and the entry valid bit is set.
REQ-032 An update and a fetch to the same index in the same cycle: the fetch sees the pre-update values (read before write).
REQ-033 oIC wraps from 32'hFFFF_FFFF to 0 and counts only REQ-023 and REQ-025 transfers.
REQ-034 imem_addr is combinational from PC; the memory returns data for the address presented in the cycle it asserts imem_ready.

Reset
REQ-035 reset=1: PC<=RESET_PC, state<=REQ, hold buffer empty, oIR/oPC/oIC<=0, oValid<=0, oPPCCB<=3'b001.
REQ-036 reset=1: all BHT counters <=2'b01, all BTB valid bits <=0, overriding every other input.
REQ-037 reset mid-HOLD or mid-request: the buffered or pending instruction is discarded, and imem_req=1 with imem_addr=RESET_PC in the first cycle after reset.

Verification
REQ-038 Reset, then imem_ready=1 for 3 cycles with data A,B,C -> oPC 0,4,8; oIR A,B,C; oValid=1; oIC=3.
REQ-039 stall=1 coincident with imem_ready for data D -> HOLD, imem_req=0, outputs frozen; after stall=0 -> oIR=D, next fetch at PC+4.
REQ-040 Three bp_upd taken updates for PC 0x10, target 0x80 -> next fetch of 0x10 gives oPPCCB=3'b111 and the following imem_addr=0x80.
REQ-041 redirect=1, redirect_pc=0x200 with imem_ready=1 in the same cycle -> the response is dropped, oValid=0, next imem_addr=0x200.
REQ-042 flush=1 and stall=1 together -> oValid=0 and oIC unchanged.
REQ-043 Preload oIC=32'hFFFF_FFFF, deliver one instruction -> oIC=0.
